// File: rtl/def_fetch.sv
// Shared fetch-stage definitions: FSM state encoding and the word substituted on a fetch timeout.
package def_fetch;

    typedef enum logic [1:0] {
        FS_IDLE = 2'b00,
        FS_REQ  = 2'b01,
        FS_HOLD = 2'b10
    } fetch_state_e;

    localparam logic [31:0] NOP_INSN = 32'h4000_0009;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Wait-cycle counter for an outstanding IM request: clear, load-to-one, increment, and an expire flag
// raised on the last cycle the request may stay open.
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic load_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next-count selection; clear wins over load, load over increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = {CW{1'b0}};
        end else if (load_i) begin
            count_d = ONE;
        end else if (inc_i) begin
            count_d = count_q + ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    // The issuing cycle counts as one, so expiring here caps im_req at TIMEOUT cycles.
    assign expire_o = (count_q >= LAST);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the IM req/ack handshake and buffers one word for ir.
// Optional PC redirect (pc_load/pc_load_value) is built when FETCH_REDIRECT_EN is defined.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    PC_STEP    = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}},
    parameter int                    TIMEOUT    = 15,
    parameter logic [31:0]           NOP_INSN   = def_fetch::NOP_INSN
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable_pc,
    input  logic                  enable_fetch,
`ifdef FETCH_REDIRECT_EN
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_value,
`endif
    output logic                  im_req,
    output logic [ADDR_WIDTH-1:0] im_addr,
    input  logic [31:0]           im_rdata,
    input  logic                  im_ack,
    output logic [31:0]           ir,
    output logic                  ir_valid,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  fetch_busy,
    output logic                  fetch_err
);

    import def_fetch::*;

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]           ir_q, ir_d;
    logic [31:0]           buf_q, buf_d;
    logic                  ir_valid_q, ir_valid_d;
    logic                  err_q, err_d;
    logic                  issue_s;
    logic                  ctr_clr_s, ctr_load_s, ctr_inc_s, ctr_expire_s;

    // A request starts from IDLE, or from HOLD in the same cycle the held word is committed.
    assign issue_s = enable_pc && ((state_q == FS_IDLE) || ((state_q == FS_HOLD) && enable_fetch));

    // Next-state, datapath and error logic.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        buf_d      = buf_q;
        err_d      = err_q;
        ctr_clr_s  = 1'b0;
        ctr_load_s = 1'b0;
        ctr_inc_s  = 1'b0;
        case (state_q)
            FS_IDLE: begin
                if (enable_fetch) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (issue_s && im_ack) begin
                    buf_d   = im_rdata;
                    pc_d    = pc_q + STEP;
                    state_d = FS_HOLD;
                end else if (issue_s) begin
                    state_d    = FS_REQ;
                    ctr_load_s = 1'b1;
                end else begin
                    state_d = FS_IDLE;
                end
            end
            FS_REQ: begin
                if (enable_pc || enable_fetch) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (im_ack) begin
                    buf_d     = im_rdata;
                    pc_d      = pc_q + STEP;
                    state_d   = FS_HOLD;
                    ctr_clr_s = 1'b1;
                end else if (ctr_expire_s) begin
                    buf_d     = NOP_INSN;
                    pc_d      = pc_q + STEP;
                    err_d     = 1'b1;
                    state_d   = FS_HOLD;
                    ctr_clr_s = 1'b1;
                end else begin
                    ctr_inc_s = 1'b1;
                end
            end
            FS_HOLD: begin
                if (enable_fetch) begin
                    ir_d       = buf_q;
                    ir_valid_d = 1'b1;
                    if (issue_s && im_ack) begin
                        buf_d   = im_rdata;
                        pc_d    = pc_q + STEP;
                        state_d = FS_HOLD;
                    end else if (issue_s) begin
                        state_d    = FS_REQ;
                        ctr_load_s = 1'b1;
                    end else begin
                        state_d = FS_IDLE;
                    end
                end else if (enable_pc) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
`ifdef FETCH_REDIRECT_EN
        pc_d  = (pc_load && (state_q != FS_REQ)) ? pc_load_value : pc_d;
        err_d = (pc_load && (state_q == FS_REQ)) ? 1'b1 : err_d;
`endif
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= FS_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= 32'h0000_0000;
            ir_valid_q <= 1'b0;
            buf_q      <= 32'h0000_0000;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            buf_q      <= buf_d;
            err_q      <= err_d;
        end
    end

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i    (clock),
        .rst_ni   (reset),
        .clr_i    (ctr_clr_s),
        .load_i   (ctr_load_s),
        .inc_i    (ctr_inc_s),
        .expire_o (ctr_expire_s)
    );

    assign im_req     = issue_s || (state_q == FS_REQ);
    assign im_addr    = pc_q;
    assign pc         = pc_q;
    assign ir         = ir_q;
    assign ir_valid   = ir_valid_q;
    assign fetch_busy = (state_q == FS_REQ);
    assign fetch_err  = err_q;

endmodule
